// File: rtl/banked_program_memory.sv
// Banked dual-port program/data memory: one fetch port, one byte-writable data port.
// Read latency is one cycle, and the bank selects are registered along with the read data.
module banked_program_memory #(
    parameter int NUM_BANKS      = 4,
    parameter int BANK_WORDS     = 2048,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] PC,
    input  logic        instr_ren,
    input  logic [31:2] address,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] data_in,
    input  logic [3:0]  byte_select_vector,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        addr_fault,
    output logic        busy
);
    localparam int OB = $clog2(BANK_WORDS);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [31:0] TOTAL_WORDS = 32'(NUM_BANKS * BANK_WORDS);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FILL = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [OB-1:0]   fill_cnt_r, fill_cnt_nxt_s;
    logic            run_s, fill_s;
    logic [OB-1:0]   pc_off_s, addr_off_s;
    logic [BW-1:0]   pc_bank_s, addr_bank_s;
    logic            pc_in_s, addr_in_s;
    logic            fetch_go_s, data_go_s, wr_go_s;
    logic [31:0]     iq_s [NUM_BANKS];
    logic [31:0]     dq_s [NUM_BANKS];
    logic [31:0]     instr_mux_s, data_mux_s;
    logic [BW-1:0]   instr_sel_r, data_sel_r;
    logic            instr_zero_r, data_zero_r;
    logic            instr_valid_r, data_valid_r, addr_fault_r;

    // Range check uses the full word address so high addresses never alias into a bank.
    assign pc_off_s    = PC[OB+1:2];
    assign addr_off_s  = address[OB+1:2];
    assign pc_bank_s   = BW'(PC[31:2+OB]);
    assign addr_bank_s = BW'(address[31:2+OB]);
    assign pc_in_s     = ({2'b00, PC} < TOTAL_WORDS);
    assign addr_in_s   = ({2'b00, address} < TOTAL_WORDS);

    assign run_s      = (state_r == ST_RUN);
    assign fill_s     = (state_r == ST_FILL);
    assign fetch_go_s = run_s & instr_ren & pc_in_s;
    assign data_go_s  = run_s & ren & addr_in_s;
    assign wr_go_s    = run_s & wen & addr_in_s;

    // Sequencer state and fill counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= (CLEAR_ON_RESET != 0) ? ST_FILL : ST_RUN;
            fill_cnt_r <= {OB{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            fill_cnt_r <= fill_cnt_nxt_s;
        end
    end

    // Next-state logic: fill walks every offset once, then RUN until reset.
    always_comb begin
        state_nxt_s    = state_r;
        fill_cnt_nxt_s = fill_cnt_r;
        case (state_r)
            ST_FILL: begin
                fill_cnt_nxt_s = fill_cnt_r + {{(OB-1){1'b0}}, 1'b1};
                if (fill_cnt_r == OB'(BANK_WORDS - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] mem_r [BANK_WORDS];
        logic [31:0] iq_r, dq_r;

        // Storage and read registers; non-blocking reads give read-first collisions.
        always_ff @(posedge clk) begin
            if (fill_s) begin
                mem_r[fill_cnt_r] <= 32'h0000_0000;
            end else if (wr_go_s && (addr_bank_s == BW'(b))) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_select_vector[i]) begin
                        mem_r[addr_off_s][8*i +: 8] <= data_in[8*i +: 8];
                    end
                end
            end
            if (fetch_go_s && (pc_bank_s == BW'(b))) begin
                iq_r <= mem_r[pc_off_s];
            end
            if (data_go_s && (addr_bank_s == BW'(b))) begin
                dq_r <= mem_r[addr_off_s];
            end
        end

        assign iq_s[b] = iq_r;
        assign dq_s[b] = dq_r;
    end

    // Registered selects, zero-return flags, valids and the fault pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_sel_r   <= {BW{1'b0}};
            data_sel_r    <= {BW{1'b0}};
            instr_zero_r  <= 1'b1;
            data_zero_r   <= 1'b1;
            instr_valid_r <= 1'b0;
            data_valid_r  <= 1'b0;
            addr_fault_r  <= 1'b0;
        end else begin
            instr_valid_r <= run_s & instr_ren;
            data_valid_r  <= run_s & ren;
            addr_fault_r  <= run_s & ((instr_ren & ~pc_in_s) | ((ren | wen) & ~addr_in_s));
            if (run_s && instr_ren) begin
                instr_zero_r <= ~pc_in_s;
                if (pc_in_s) begin
                    instr_sel_r <= pc_bank_s;
                end
            end
            if (run_s && ren) begin
                data_zero_r <= ~addr_in_s;
                if (addr_in_s) begin
                    data_sel_r <= addr_bank_s;
                end
            end
        end
    end

    // Output mux driven only by registered bank selects.
    always_comb begin
        instr_mux_s = 32'h0000_0000;
        data_mux_s  = 32'h0000_0000;
        for (int b = 0; b < NUM_BANKS; b++) begin
            instr_mux_s = (instr_sel_r == BW'(b)) ? iq_s[b] : instr_mux_s;
            data_mux_s  = (data_sel_r  == BW'(b)) ? dq_s[b] : data_mux_s;
        end
    end

    assign instr       = instr_zero_r ? 32'h0000_0000 : instr_mux_s;
    assign data_out    = data_zero_r  ? 32'h0000_0000 : data_mux_s;
    assign instr_valid = instr_valid_r;
    assign data_valid  = data_valid_r;
    assign addr_fault  = addr_fault_r;
    assign busy        = fill_s;

endmodule

// File: tb/tb_banked_program_memory.sv
// Directed bench: a 4-bank and a 3-bank preserved memory share stimulus; a 16-word zero-fill instance covers the sequencer.
module tb_banked_program_memory;
    logic        clk = 1'b0;
    logic        rst_ab = 1'b0;
    logic        rst_c = 1'b0;
    logic [31:2] pc = 30'h0;
    logic        instr_ren = 1'b0;
    logic [31:2] address = 30'h0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [3:0]  bsv = 4'h0;

    logic [31:0] instr_a, data_a, instr_b, data_b, instr_c, data_c;
    logic        iv_a, dv_a, af_a, busy_a;
    logic        iv_b, dv_b, af_b, busy_b;
    logic        iv_c, dv_c, af_c, busy_c;

    int n_vec = 0;
    int n_bad = 0;
    int fill_len;

    always #5 clk = ~clk;

    banked_program_memory #(.NUM_BANKS(4), .BANK_WORDS(2048), .CLEAR_ON_RESET(0)) dut_a (
        .clk(clk), .reset(rst_ab), .PC(pc), .instr_ren(instr_ren), .address(address),
        .ren(ren), .wen(wen), .data_in(data_in), .byte_select_vector(bsv),
        .instr(instr_a), .instr_valid(iv_a), .data_out(data_a), .data_valid(dv_a),
        .addr_fault(af_a), .busy(busy_a));

    banked_program_memory #(.NUM_BANKS(3), .BANK_WORDS(2048), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset(rst_ab), .PC(pc), .instr_ren(instr_ren), .address(address),
        .ren(ren), .wen(wen), .data_in(data_in), .byte_select_vector(bsv),
        .instr(instr_b), .instr_valid(iv_b), .data_out(data_b), .data_valid(dv_b),
        .addr_fault(af_b), .busy(busy_b));

    banked_program_memory #(.NUM_BANKS(4), .BANK_WORDS(16), .CLEAR_ON_RESET(1)) dut_c (
        .clk(clk), .reset(rst_c), .PC(pc), .instr_ren(instr_ren), .address(address),
        .ren(ren), .wen(wen), .data_in(data_in), .byte_select_vector(bsv),
        .instr(instr_c), .instr_valid(iv_c), .data_out(data_c), .data_valid(dv_c),
        .addr_fault(af_c), .busy(busy_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:2] a, input logic [31:0] d, input logic [3:0] be);
        address = a; data_in = d; bsv = be; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [31:2] a);
        address = a; ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_instr", instr_a, 32'h0);
        check("rst_data", data_a, 32'h0);
        check("rst_ivalid", {31'b0, iv_a}, 32'd0);
        check("rst_dvalid", {31'b0, dv_a}, 32'd0);
        check("rst_fault", {31'b0, af_a}, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("rst_busy_c", {31'b0, busy_c}, 32'd1);
        rst_ab = 1'b1;
        tick();

        // Distinct words at offset 0 of every bank; 0x1800 is out of range for the 3-bank part
        wr(30'h0000, 32'hA0A0_A0A0, 4'hF);
        wr(30'h0800, 32'hB1B1_B1B1, 4'hF);
        wr(30'h1000, 32'hC2C2_C2C2, 4'hF);
        wr(30'h1800, 32'hDEAD_BEEF, 4'hF);
        check("b_wr_fault", {31'b0, af_b}, 32'd1);
        check("a_wr_nofault", {31'b0, af_a}, 32'd0);
        tick();
        check("b_fault_pulse_end", {31'b0, af_b}, 32'd0);

        rd(30'h1800);
        check("a_rd_bank3", data_a, 32'hDEAD_BEEF);
        check("a_rd_bank3_valid", {31'b0, dv_a}, 32'd1);
        check("b_oor_data", data_b, 32'h0);
        check("b_oor_valid", {31'b0, dv_b}, 32'd1);
        check("b_oor_fault", {31'b0, af_b}, 32'd1);
        tick();
        check("a_hold_data", data_a, 32'hDEAD_BEEF);
        check("a_hold_valid", {31'b0, dv_a}, 32'd0);
        check("b_oor_fault_end", {31'b0, af_b}, 32'd0);
        rd(30'h0000);
        check("a_bank0", data_a, 32'hA0A0_A0A0);
        check("b_bank0_untouched", data_b, 32'hA0A0_A0A0);
        rd(30'h0800);
        check("a_bank1", data_a, 32'hB1B1_B1B1);
        rd(30'h1000);
        check("a_bank2", data_a, 32'hC2C2_C2C2);
        check("b_bank2", data_b, 32'hC2C2_C2C2);

        // Byte enables
        wr(30'h0005, 32'h1122_3344, 4'hF);
        wr(30'h0005, 32'hAABB_CCDD, 4'b0101);
        wr(30'h0005, 32'hFFFF_FFFF, 4'b0000);
        rd(30'h0005);
        check("byte_merge", data_a, 32'h11BB_33DD);

        // Back-to-back fetches across a bank boundary, then a stall
        wr(30'h07FF, 32'h7FF0_7FF0, 4'hF);
        instr_ren = 1'b1; pc = 30'h07FF;
        tick();
        check("fetch_7ff", instr_a, 32'h7FF0_7FF0);
        check("fetch_7ff_valid", {31'b0, iv_a}, 32'd1);
        pc = 30'h0800;
        tick();
        check("fetch_800", instr_a, 32'hB1B1_B1B1);
        instr_ren = 1'b0; pc = 30'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", instr_a, 32'hB1B1_B1B1);
            check("stall_valid", {31'b0, iv_a}, 32'd0);
        end

        // Read-first collision on both ports
        wr(30'h0010, 32'h0000_0000, 4'hF);
        pc = 30'h0010; address = 30'h0010; instr_ren = 1'b1; ren = 1'b1;
        wen = 1'b1; data_in = 32'h0000_0055; bsv = 4'hF;
        tick();
        wen = 1'b0;
        check("coll_instr_old", instr_a, 32'h0);
        check("coll_data_old", data_a, 32'h0);
        tick();
        check("coll_instr_new", instr_a, 32'h0000_0055);
        check("coll_data_new", data_a, 32'h0000_0055);

        // Simultaneous fetch and data faults; 0x2000 would alias to word 0 if truncated
        pc = 30'h2000; address = 30'h3FFF_FFFF;
        tick();
        instr_ren = 1'b0; ren = 1'b0;
        check("oor_instr", instr_a, 32'h0);
        check("oor_ivalid", {31'b0, iv_a}, 32'd1);
        check("oor_data", data_a, 32'h0);
        check("oor_fault", {31'b0, af_a}, 32'd1);
        tick();
        check("oor_single_pulse", {31'b0, af_a}, 32'd0);
        wr(30'h2000, 32'hFFFF_FFFF, 4'hF);
        rd(30'h0000);
        check("oor_wr_dropped", data_a, 32'hA0A0_A0A0);

        // Zero-fill sequencer: requests during fill must be ignored
        pc = 30'h0000; instr_ren = 1'b1; address = 30'h3FFF_FFFF; ren = 1'b1;
        rst_c = 1'b1;
        check("fill_busy_start", {31'b0, busy_c}, 32'd1);
        for (int k = 0; k < 7; k++) tick();
        check("fill_busy_mid", {31'b0, busy_c}, 32'd1);
        check("fill_ivalid", {31'b0, iv_c}, 32'd0);
        check("fill_dvalid", {31'b0, dv_c}, 32'd0);
        check("fill_nofault", {31'b0, af_c}, 32'd0);
        instr_ren = 1'b0; ren = 1'b0;
        rst_c = 1'b0;
        #2;
        check("fill_busy_in_reset", {31'b0, busy_c}, 32'd1);
        rst_c = 1'b1;
        fill_len = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            fill_len++;
            if (!busy_c) break;
        end
        check("fill_length", 32'(fill_len), 32'd16);
        for (int w = 0; w < 64; w++) begin
            rd(30'(w));
            check("fill_zero", data_c, 32'h0);
        end
        check("fill_done_valid", {31'b0, dv_c}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
